// File: rtl/audio_mem_sched.sv
// Capture RAM sequencer: time-shares the audio RAM between sinc3 capture, UART byte dump and I2S playback.
// Optional AUDIO_SCHED_ABORT_EN: a button edge outside IDLE aborts the running activity.
module audio_mem_sched #(
   parameter int RAM_SIZE   = 65536,
   parameter int DATA_WIDTH = 16,
   localparam int AW = $clog2(RAM_SIZE),
   localparam int NB = DATA_WIDTH / 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_btn_capture,
   input  logic                  i_btn_dump,
   input  logic                  i_btn_play,
   input  logic [DATA_WIDTH-1:0] i_sample_in,
   input  logic                  i_sample_valid,
   output logic                  o_ram_we,
   output logic [AW-1:0]         o_ram_wraddr,
   output logic [DATA_WIDTH-1:0] o_ram_wrdata,
   output logic [AW-1:0]         o_ram_rdaddr,
   input  logic [DATA_WIDTH-1:0] i_ram_dout,
   output logic [7:0]            o_uart_data,
   output logic                  o_tx_start,
   input  logic                  i_tx_busy,
   input  logic                  i_tx_done,
   output logic                  o_i2s_start,
   input  logic                  i_inc_mem,
   output logic [3:0]            o_led,
   output logic                  o_busy
);

   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
   localparam logic [AW-1:0] QMASK     = AW'(RAM_SIZE / 4 - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_DUMP_LOAD, S_DUMP_TX, S_DUMP_WAIT, S_PLAY
   } state_t;

   state_t r_state, w_next;

   logic [2:0]            r_sync_cap, r_sync_dmp, r_sync_ply;
   logic                  r_we, r_tx_start, r_i2s, r_abort_pend;
   logic [AW-1:0]         r_wraddr, r_rdaddr;
   logic [DATA_WIDTH-1:0] r_wrdata;
   logic [7:0]            r_uart_data;
   logic [3:0]            r_led;
   logic [KW-1:0]         r_k;

   logic w_cap_edge, w_dmp_edge, w_ply_edge, w_any_edge;
   logic w_abort_req, w_abort_now, w_tx_fire;
   logic w_wr_last, w_rd_last, w_rd_qtr_end, w_byte_last;
   logic [1:0] w_wr_qtr, w_rd_qtr;

   // Raw pushbuttons: three-flop synchronizers, rising edge on the two oldest flops
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync_cap <= '0;
         r_sync_dmp <= '0;
         r_sync_ply <= '0;
      end else begin
         r_sync_cap <= {r_sync_cap[1:0], i_btn_capture};
         r_sync_dmp <= {r_sync_dmp[1:0], i_btn_dump};
         r_sync_ply <= {r_sync_ply[1:0], i_btn_play};
      end
   end

   assign w_cap_edge = r_sync_cap[1] & ~r_sync_cap[2];
   assign w_dmp_edge = r_sync_dmp[1] & ~r_sync_dmp[2];
   assign w_ply_edge = r_sync_ply[1] & ~r_sync_ply[2];
   assign w_any_edge = w_cap_edge | w_dmp_edge | w_ply_edge;

   assign w_wr_last    = r_we && (r_wraddr == LAST_ADDR);
   assign w_rd_last    = (r_rdaddr == LAST_ADDR);
   assign w_rd_qtr_end = ((r_rdaddr & QMASK) == QMASK);
   assign w_byte_last  = (r_k == KW'(NB - 1));
   assign w_wr_qtr     = r_wraddr[AW-1 -: 2];
   assign w_rd_qtr     = r_rdaddr[AW-1 -: 2];

`ifdef AUDIO_SCHED_ABORT_EN
   assign w_abort_req = w_any_edge && (r_state != S_IDLE);
`else
   assign w_abort_req = 1'b0;
`endif

   // A byte already handed to the UART is allowed to finish before aborting
   always_comb begin
      w_abort_now = 1'b0;
      if (r_state == S_DUMP_WAIT)
         w_abort_now = (w_abort_req || r_abort_pend) && i_tx_done;
      else
         w_abort_now = w_abort_req;
   end

   assign w_tx_fire = (r_state == S_DUMP_TX) && !i_tx_busy && !w_abort_now;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_abort_now) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cap_edge)      w_next = S_CAPTURE;
               else if (w_dmp_edge) w_next = S_DUMP_LOAD;
               else if (w_ply_edge) w_next = S_PLAY;
            end
            S_CAPTURE:   if (w_wr_last) w_next = S_IDLE;
            S_DUMP_LOAD: w_next = S_DUMP_TX;
            S_DUMP_TX:   if (!i_tx_busy) w_next = S_DUMP_WAIT;
            S_DUMP_WAIT: begin
               if (i_tx_done) begin
                  if (!w_byte_last)   w_next = S_DUMP_TX;
                  else if (w_rd_last) w_next = S_IDLE;
                  else                w_next = S_DUMP_LOAD;
               end
            end
            S_PLAY:  if (i_inc_mem && w_rd_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_we         <= 1'b0;
         r_tx_start   <= 1'b0;
         r_i2s        <= 1'b0;
         r_abort_pend <= 1'b0;
         r_wraddr     <= '0;
         r_rdaddr     <= '0;
         r_wrdata     <= '0;
         r_uart_data  <= '0;
         r_led        <= '0;
         r_k          <= '0;
      end else begin
         r_tx_start   <= w_tx_fire;
         r_we         <= (r_state == S_CAPTURE) && i_sample_valid && !w_wr_last && !w_abort_now;
         r_abort_pend <= (r_state == S_DUMP_WAIT) && (r_abort_pend || w_abort_req) && !i_tx_done;
         if ((r_state == S_CAPTURE) && i_sample_valid)
            r_wrdata <= i_sample_in;
         if (w_tx_fire)
            r_uart_data <= i_ram_dout[{r_k, 3'b000} +: 8];

         if (w_abort_now) begin
            r_wraddr <= '0;
            r_rdaddr <= '0;
            r_led    <= '0;
            r_i2s    <= 1'b0;
            r_k      <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_cap_edge) begin
                     r_wraddr <= '0;
                     r_led    <= '0;
                  end else if (w_dmp_edge) begin
                     r_rdaddr <= '0;
                     r_led    <= 4'hF;
                     r_k      <= '0;
                  end else if (w_ply_edge) begin
                     r_rdaddr <= '0;
                     r_i2s    <= 1'b1;
                     r_led    <= 4'hF;
                  end
               end
               // Address advances in the cycle the write is presented, wrapping to 0 after the last word
               S_CAPTURE: begin
                  if (r_we) begin
                     r_wraddr        <= r_wraddr + 1'b1;
                     r_led[w_wr_qtr] <= 1'b1;
                  end
               end
               S_DUMP_WAIT: begin
                  if (i_tx_done) begin
                     if (!w_byte_last) begin
                        r_k <= r_k + 1'b1;
                     end else begin
                        r_k      <= '0;
                        r_rdaddr <= r_rdaddr + 1'b1;
                        if (w_rd_qtr_end) r_led[2'd3 - w_rd_qtr] <= 1'b0;
                     end
                  end
               end
               S_PLAY: begin
                  if (i_inc_mem) begin
                     r_rdaddr <= r_rdaddr + 1'b1;
                     if (w_rd_qtr_end) r_led[w_rd_qtr] <= 1'b0;
                     if (w_rd_last)    r_i2s <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_ram_we     = r_we;
   assign o_ram_wraddr = r_wraddr;
   assign o_ram_wrdata = r_wrdata;
   assign o_ram_rdaddr = r_rdaddr;
   assign o_uart_data  = r_uart_data;
   assign o_tx_start   = r_tx_start;
   assign o_i2s_start  = r_i2s;
   assign o_led        = r_led;
   assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_audio_mem_sched.sv
// Directed bench for audio_mem_sched with a 16-word RAM model and a scripted UART/I2S handshake.
module tb_audio_mem_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        btn_capture, btn_dump, btn_play;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        ram_we;
   logic [3:0]  ram_wraddr, ram_rdaddr;
   logic [15:0] ram_wrdata, ram_dout;
   logic [7:0]  uart_data;
   logic        tx_start, tx_busy, tx_done;
   logic        i2s_start, inc_mem;
   logic [3:0]  led;
   logic        busy;

   logic [15:0] mem [16];
   logic        tb_we;
   logic [3:0]  tb_wa;
   logic [15:0] tb_wd;

   int n_tests = 0;
   int n_fail  = 0;
   int n_starts = 0, n_viol = 0, n_dbl = 0;
   logic pend = 1'b0;

   always #5 clk = ~clk;

   audio_mem_sched #(.RAM_SIZE(16), .DATA_WIDTH(16)) dut (
      .i_clk(clk), .i_reset_n(reset_n),
      .i_btn_capture(btn_capture), .i_btn_dump(btn_dump), .i_btn_play(btn_play),
      .i_sample_in(sample_in), .i_sample_valid(sample_valid),
      .o_ram_we(ram_we), .o_ram_wraddr(ram_wraddr), .o_ram_wrdata(ram_wrdata),
      .o_ram_rdaddr(ram_rdaddr), .i_ram_dout(ram_dout),
      .o_uart_data(uart_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy), .i_tx_done(tx_done),
      .o_i2s_start(i2s_start), .i_inc_mem(inc_mem), .o_led(led), .o_busy(busy)
   );

   // Synchronous-read RAM with a side port for the bench to plant words
   always @(posedge clk) begin
      if (ram_we)     mem[ram_wraddr] <= ram_wrdata;
      else if (tb_we) mem[tb_wa] <= tb_wd;
      ram_dout <= mem[ram_rdaddr];
   end

   always @(posedge clk) begin
      if (tx_start) begin
         n_starts++;
         if (tx_busy) n_viol++;
         if (pend) n_dbl++;
         pend = 1'b1;
      end
      if (tx_done) pend = 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start();
      for (int c = 0; c < 20 && !tx_start; c++) tick();
      chk("tx_start_seen", 32'(tx_start), 32'd1);
   endtask

   initial begin
      int s0;
      logic [7:0] eb;
      logic [15:0] ew;
      reset_n = 1'b0; btn_capture = 0; btn_dump = 0; btn_play = 0;
      sample_in = '0; sample_valid = 0; tx_busy = 0; tx_done = 0; inc_mem = 0;
      tb_we = 0; tb_wa = '0; tb_wd = '0;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0;
      tick(); tick();
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_led", 32'(led), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_i2s", 32'(i2s_start), 0);
      chk("rst_txs", 32'(tx_start), 0);
      chk("rst_addr", {ram_wraddr, ram_rdaddr}, 0);
      reset_n = 1'b1;
      tick();

      // ignored events in IDLE
      sample_valid = 1; inc_mem = 1; tx_done = 1;
      tick();
      sample_valid = 0; inc_mem = 0; tx_done = 0;
      chk("idle_ign_we", 32'(ram_we), 0);
      chk("idle_ign_rd", 32'(ram_rdaddr), 0);
      chk("idle_ign_busy", 32'(busy), 0);

      // capture and play together: capture wins, latency N+2
      btn_capture = 1; btn_play = 1;
      tick(); tick();
      chk("cap_n1_busy", 32'(busy), 0);
      tick();
      chk("cap_n2_busy", 32'(busy), 1);
      chk("cap_no_play", 32'(i2s_start), 0);
      btn_capture = 0; btn_play = 0;
      for (int i = 0; i < 16; i++) begin
`ifndef AUDIO_SCHED_ABORT_EN
         if (i == 2) btn_dump = 1;
         if (i == 6) btn_dump = 0;
`endif
         sample_in = 16'h1000 + 16'(i); sample_valid = 1;
         tick();
         chk("cap_we", 32'(ram_we), 1);
         chk("cap_addr", 32'(ram_wraddr), 32'(i));
         chk("cap_data", 32'(ram_wrdata), 32'h1000 + 32'(i));
         if (i == 4)  chk("cap_led4", 32'(led), 32'h1);
         if (i == 15) chk("cap_busy15", 32'(busy), 1);
         if (i < 8) begin
            sample_valid = 0;
            tick();
         end
      end
      sample_valid = 0;
      tick();
      chk("cap_end_busy", 32'(busy), 0);
      chk("cap_end_we", 32'(ram_we), 0);
      chk("cap_end_addr", 32'(ram_wraddr), 0);
      chk("cap_end_led", 32'(led), 32'hF);
      chk("cap_mem5", 32'(mem[5]), 32'h1005);

      // dump with 0xC2A3 planted at word 0
      tb_we = 1; tb_wa = 4'd0; tb_wd = 16'hC2A3;
      tick();
      tb_we = 0;
      s0 = n_starts;
      tx_busy = 1; btn_dump = 1;
      tick(); tick(); tick();
      chk("dmp_busy", 32'(busy), 1);
      chk("dmp_led", 32'(led), 32'hF);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("dmp_hold_busy", 32'(tx_start), 0);
      end
      tx_busy = 0; btn_dump = 0;
      for (int w = 0; w < 16; w++) begin
         for (int b = 0; b < 2; b++) begin
            wait_start();
            if (w == 0) eb = (b == 0) ? 8'hA3 : 8'hC2;
            else        eb = (b == 0) ? 8'(w) : 8'h10;
            chk("dmp_byte", 32'(uart_data), 32'(eb));
            chk("dmp_rdaddr", 32'(ram_rdaddr), 32'(w));
            tick();
            chk("dmp_pulse", 32'(tx_start), 0);
            tx_busy = 1;
            tick(); tick();
            chk("dmp_rd_stable", 32'(ram_rdaddr), 32'(w));
            tx_busy = 0; tx_done = 1;
            tick();
            tx_done = 0;
            if (b == 1) chk("dmp_led", 32'(led), 32'(4'hF >> ((w + 1) / 4)));
         end
      end
      chk("dmp_end_busy", 32'(busy), 0);
      chk("dmp_end_rd", 32'(ram_rdaddr), 0);
      chk("dmp_starts", 32'(n_starts - s0), 32);
      chk("dmp_viol", 32'(n_viol), 0);
      chk("dmp_dbl", 32'(n_dbl), 0);

      // playback
      btn_play = 1;
      tick(); tick();
      chk("ply_n1", 32'(i2s_start), 0);
      tick();
      chk("ply_n2", 32'(i2s_start), 1);
      chk("ply_led", 32'(led), 32'hF);
      btn_play = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         ew = (i == 0) ? 16'hC2A3 : 16'h1000 + 16'(i);
         chk("ply_rd", 32'(ram_rdaddr), 32'(i));
         chk("ply_dout", 32'(ram_dout), 32'(ew));
         chk("ply_i2s", 32'(i2s_start), 1);
         inc_mem = 1;
         tick();
         inc_mem = 0;
         if (i == 3) chk("ply_led3", 32'(led), 32'hE);
      end
      chk("ply_end_i2s", 32'(i2s_start), 0);
      chk("ply_end_busy", 32'(busy), 0);
      chk("ply_end_rd", 32'(ram_rdaddr), 0);
      chk("ply_end_led", 32'(led), 0);

      // reset in the middle of a capture
      btn_capture = 1;
      tick(); tick(); tick();
      btn_capture = 0;
      sample_in = 16'h5555; sample_valid = 1;
      tick(); tick();
      chk("rstm_we_pre", 32'(ram_we), 1);
      #2 reset_n = 0;
      #1;
      chk("rstm_we", 32'(ram_we), 0);
      chk("rstm_wraddr", 32'(ram_wraddr), 0);
      chk("rstm_busy", 32'(busy), 0);
      sample_valid = 0;
      tick();
      reset_n = 1;
      tick();
      chk("rstm_mem5", 32'(mem[5]), 32'h1005);

`ifdef AUDIO_SCHED_ABORT_EN
      // play button during DUMP_WAIT: in-flight byte finishes, then abort
      s0 = n_starts;
      btn_dump = 1;
      tick(); tick(); tick();
      btn_dump = 0;
      wait_start();
      tick();
      tx_busy = 1; btn_play = 1;
      tick(); tick(); tick(); tick();
      btn_play = 0;
      chk("abt_still_busy", 32'(busy), 1);
      tx_busy = 0; tx_done = 1;
      tick();
      tx_done = 0;
      chk("abt_idle", 32'(busy), 0);
      chk("abt_led", 32'(led), 0);
      chk("abt_rd", 32'(ram_rdaddr), 0);
      for (int c = 0; c < 10; c++) tick();
      chk("abt_starts", 32'(n_starts - s0), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
